// File: rtl/axi_stream_pkg.sv
// Shared defaults, FSM state encoding and byte-count helpers for the AXI-Stream header stages.
package axi_stream_pkg;

  localparam int DATA_WD_DEF      = 32;
  localparam int DATA_BYTE_WD_DEF = DATA_WD_DEF / 8;
  localparam int MAX_BYTES        = 64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;
  localparam logic [1:0] ST_TAIL = 2'd3;

  function automatic int popcount(input logic [MAX_BYTES-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

  // Top cnt bits of an nbytes-wide keep set; callers truncate to their lane count.
  function automatic logic [MAX_BYTES-1:0] keep_msb(input int cnt, input int nbytes);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      m[i] = (i < nbytes) && (i >= nbytes - cnt);
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_byte_realign.sv
// Combinational byte re-alignment: masks the incoming beat, splits it at the k-byte header
// boundary, and joins the carried residual with the new beat's top k bytes.
module axis_byte_realign
  import axi_stream_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic [DATA_WD-1:0]      data_i,
  input  logic [DATA_BYTE_WD-1:0] keep_i,
  input  logic [DATA_WD-1:0]      residual_i,
  input  logic [BYTE_CNT_WD:0]    k_i,
  input  logic [BYTE_CNT_WD:0]    r_i,
  output logic [DATA_WD-1:0]      beat_o,
  output logic [BYTE_CNT_WD:0]    n_o,
  output logic [DATA_WD-1:0]      hdr_dat_o,
  output logic [DATA_WD-1:0]      body_dat_o,
  output logic [DATA_WD-1:0]      tail_dat_o,
  output logic [DATA_BYTE_WD-1:0] body_last_keep_o,
  output logic [DATA_BYTE_WD-1:0] tail_keep_o
);

  localparam int CW = BYTE_CNT_WD + 1;

  int hsh;
  int ksh;

  // Invalid lanes are forced to zero so every padding byte downstream is zero.
  always_comb begin
    beat_o = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      beat_o[8*i +: 8] = data_i[8*i +: 8] & {8{keep_i[i]}};
    end
  end

  always_comb begin
    hsh = 8 * (DATA_BYTE_WD - int'(k_i));
    ksh = 8 * int'(k_i);
  end

  assign n_o        = CW'(popcount(MAX_BYTES'(keep_i)));
  assign hdr_dat_o  = beat_o >> hsh;
  assign tail_dat_o = residual_i << ksh;
  assign body_dat_o = (residual_i << ksh) | (beat_o >> hsh);

  assign body_last_keep_o = DATA_BYTE_WD'(keep_msb(DATA_BYTE_WD - int'(k_i) + int'(n_o), DATA_BYTE_WD));
  assign tail_keep_o      = DATA_BYTE_WD'(keep_msb(int'(r_i), DATA_BYTE_WD));

endmodule

// File: rtl/axi_stream_extract_header.sv
// Strips a 0..B byte header from each packet onto a side channel and re-aligns the payload
// to the MSB lane; one cycle of latency, each output register loads only when it is free.
module axi_stream_extract_header
  import axi_stream_pkg::*;
#(
  parameter int DATA_WD      = DATA_WD_DEF,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_extract,
  input  logic [DATA_BYTE_WD-1:0] keep_extract,
  output logic                    ready_extract,
  output logic                    valid_hdr,
  output logic [DATA_WD-1:0]      data_hdr,
  output logic [DATA_BYTE_WD-1:0] keep_hdr,
  input  logic                    ready_hdr
);

  localparam int CW = BYTE_CNT_WD + 1;
  localparam logic [DATA_BYTE_WD-1:0] KEEP_ALL = '1;

  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           k_q, k_d, r_q, r_d;
  logic [DATA_BYTE_WD-1:0] kext_q, kext_d;
  logic [DATA_WD-1:0]      residual_q, residual_d;
  logic                    valid_out_q, valid_out_d, last_out_q, last_out_d;
  logic [DATA_WD-1:0]      data_out_q, data_out_d;
  logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
  logic                    valid_hdr_q, valid_hdr_d;
  logic [DATA_WD-1:0]      data_hdr_q, data_hdr_d;
  logic [DATA_BYTE_WD-1:0] keep_hdr_q, keep_hdr_d;

  logic                    pay_free, hdr_free, in_acc;
  logic [DATA_WD-1:0]      beat, hdr_dat, body_dat, tail_dat;
  logic [CW-1:0]           n;
  logic [DATA_BYTE_WD-1:0] body_last_keep, tail_keep;

  assign pay_free      = !valid_out_q || ready_out;
  assign hdr_free      = !valid_hdr_q || ready_hdr;
  assign ready_extract = (state_q == ST_IDLE);
  // A still-pending header only blocks the first beat of the next packet.
  assign ready_in      = ((state_q == ST_HDR) && hdr_free && pay_free) ||
                         ((state_q == ST_BODY) && pay_free);
  assign in_acc        = valid_in && ready_in;

  axis_byte_realign #(
    .DATA_WD     (DATA_WD),
    .DATA_BYTE_WD(DATA_BYTE_WD),
    .BYTE_CNT_WD (BYTE_CNT_WD)
  ) u_realign (
    .data_i          (data_in),
    .keep_i          (keep_in),
    .residual_i      (residual_q),
    .k_i             (k_q),
    .r_i             (r_q),
    .beat_o          (beat),
    .n_o             (n),
    .hdr_dat_o       (hdr_dat),
    .body_dat_o      (body_dat),
    .tail_dat_o      (tail_dat),
    .body_last_keep_o(body_last_keep),
    .tail_keep_o     (tail_keep)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    r_d         = r_q;
    kext_d      = kext_q;
    residual_d  = residual_q;
    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    keep_out_d  = keep_out_q;
    last_out_d  = last_out_q;
    valid_hdr_d = valid_hdr_q;
    data_hdr_d  = data_hdr_q;
    keep_hdr_d  = keep_hdr_q;
    if (pay_free) valid_out_d = 1'b0;
    if (hdr_free) valid_hdr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_extract) begin
          k_d     = CW'(popcount(MAX_BYTES'(keep_extract)));
          kext_d  = keep_extract;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (in_acc) begin
          if (k_q != '0) begin
            data_hdr_d  = hdr_dat;
            keep_hdr_d  = kext_q;
            valid_hdr_d = 1'b1;
          end
          residual_d = beat;
          r_d        = (n > k_q) ? n - k_q : '0;
          if (!last_in)     state_d = ST_BODY;
          else if (n > k_q) state_d = ST_TAIL;
          else              state_d = ST_IDLE;
        end
      end
      ST_BODY: begin
        if (in_acc) begin
          data_out_d  = body_dat;
          keep_out_d  = KEEP_ALL;
          last_out_d  = 1'b0;
          valid_out_d = 1'b1;
          residual_d  = beat;
          if (last_in) begin
            if (n <= k_q) begin
              last_out_d = 1'b1;
              keep_out_d = body_last_keep;
              state_d    = ST_IDLE;
            end else begin
              r_d     = n - k_q;
              state_d = ST_TAIL;
            end
          end
        end
      end
      ST_TAIL: begin
        if (pay_free) begin
          data_out_d  = tail_dat;
          keep_out_d  = tail_keep;
          last_out_d  = 1'b1;
          valid_out_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      r_q         <= '0;
      kext_q      <= '0;
      residual_q  <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      keep_out_q  <= '0;
      last_out_q  <= 1'b0;
      valid_hdr_q <= 1'b0;
      data_hdr_q  <= '0;
      keep_hdr_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      r_q         <= r_d;
      kext_q      <= kext_d;
      residual_q  <= residual_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      keep_out_q  <= keep_out_d;
      last_out_q  <= last_out_d;
      valid_hdr_q <= valid_hdr_d;
      data_hdr_q  <= data_hdr_d;
      keep_hdr_q  <= keep_hdr_d;
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign keep_out  = keep_out_q;
  assign last_out  = last_out_q;
  assign valid_hdr = valid_hdr_q;
  assign data_hdr  = data_hdr_q;
  assign keep_hdr  = keep_hdr_q;

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Bench for axi_stream_extract_header: byte-stream reference model feeding a scoreboard,
// plus literal expectations on the directed packets.
module tb_axi_stream_extract_header;

  localparam int DW = 32;
  localparam int B  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [B-1:0]  keep_in = '0;
  logic          last_in = 1'b0;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic [B-1:0]  keep_out;
  logic          last_out;
  logic          ready_out = 1'b1;
  logic          valid_extract = 1'b0;
  logic [B-1:0]  keep_extract = '0;
  logic          ready_extract;
  logic          valid_hdr;
  logic [DW-1:0] data_hdr;
  logic [B-1:0]  keep_hdr;
  logic          ready_hdr = 1'b1;

  int errors = 0;
  int checks = 0;
  bit rand_rdy = 1'b0;
  bit hdr_hold = 1'b0;

  typedef struct { logic [DW-1:0] d; logic [B-1:0] k; logic l; } beat_t;
  beat_t exp_out[$];
  beat_t obs_out[$];
  beat_t exp_hdr[$];
  beat_t obs_hdr[$];
  logic [DW-1:0] pk_d[$];
  logic [B-1:0]  pk_k[$];

  always #5 clk = ~clk;

  axi_stream_extract_header #(.DATA_WD(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
    .valid_extract(valid_extract), .keep_extract(keep_extract), .ready_extract(ready_extract),
    .valid_hdr(valid_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr), .ready_hdr(ready_hdr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Sink readiness changes just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    ready_out = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    ready_hdr = !hdr_hold;
  end

  initial begin : scoreboard
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (valid_out && ready_out) begin
          obs_out.push_back('{d: data_out, k: keep_out, l: last_out});
          if (exp_out.size() == 0) begin
            checks++; errors++;
            $display("FAIL out_unexpected: got data %h keep %b, required no beat", data_out, keep_out);
          end else begin
            e = exp_out.pop_front();
            chk("out_data", data_out, e.d);
            chk("out_keep", 32'(keep_out), 32'(e.k));
            chk("out_last", 32'(last_out), 32'(e.l));
          end
        end
        if (valid_hdr && ready_hdr) begin
          obs_hdr.push_back('{d: data_hdr, k: keep_hdr, l: 1'b0});
          if (exp_hdr.size() == 0) begin
            checks++; errors++;
            $display("FAIL hdr_unexpected: got %h, required no header", data_hdr);
          end else begin
            e = exp_hdr.pop_front();
            chk("hdr_data", data_hdr, e.d);
            chk("hdr_keep", 32'(keep_hdr), 32'(e.k));
          end
        end
      end
    end
  end

  // Reference: flatten the packet to bytes, first k go to the header, the rest re-chunked.
  task automatic model(input logic [B-1:0] kext);
    logic [7:0]    by[$];
    logic [DW-1:0] h;
    beat_t         e;
    int            k, n0, start;
    k  = $countones(kext);
    n0 = $countones(pk_k[0]);
    for (int i = 0; i < pk_d.size(); i++)
      for (int j = B - 1; j >= 0; j--)
        if (pk_k[i][j]) by.push_back(pk_d[i][8*j +: 8]);
    if (k > 0) begin
      h = '0;
      for (int j = 0; j < k; j++) h = (h << 8) | {24'h0, (j < n0) ? by[j] : 8'h00};
      exp_hdr.push_back('{d: h, k: kext, l: 1'b0});
    end
    start = (k < n0) ? k : n0;
    for (int p = start; p < by.size(); p += B) begin
      e = '{d: '0, k: '0, l: (p + B >= by.size())};
      for (int j = 0; j < B; j++)
        if (p + j < by.size()) begin
          e.d[8*(B-1-j) +: 8] = by[p+j];
          e.k[B-1-j] = 1'b1;
        end
      exp_out.push_back(e);
    end
  endtask

  task automatic wait_hs(input string nm, input bit is_desc, input bit first);
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (first && valid_hdr && !ready_hdr) chk("first_beat_stall", 32'(ready_in), 32'd0);
      if (is_desc ? ready_extract : ready_in) break;
      cyc++;
      if (cyc > 300) begin
        checks++; errors++;
        $display("FAIL %s_timeout: no handshake within 300 cycles", nm);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_desc(input logic [B-1:0] kext);
    valid_extract = 1'b1;
    keep_extract  = kext;
    wait_hs("desc", 1'b1, 1'b0);
    valid_extract = 1'b0;
  endtask

  task automatic do_beat(input logic [DW-1:0] d, input logic [B-1:0] k, input bit l, input bit first);
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    wait_hs("beat", 1'b0, first);
  endtask

  task automatic idle_in();
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
  endtask

  task automatic send_pkt(input logic [B-1:0] kext);
    model(kext);
    do_desc(kext);
    for (int i = 0; i < pk_d.size(); i++)
      do_beat(pk_d[i], pk_k[i], i == pk_d.size() - 1, i == 0);
    idle_in();
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((exp_out.size() != 0 || exp_hdr.size() != 0) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    chk("drain_out_left", exp_out.size(), 0);
    chk("drain_hdr_left", exp_hdr.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_out.delete();
    obs_hdr.delete();
  endtask

  task automatic load_k2_pkt();
    pk_d = '{32'hAABBCCDD, 32'h11223344, 32'h55667788};
    pk_k = '{4'hF, 4'hF, 4'hF};
  endtask

  initial begin
    #12;
    chk("rst_valid_out", 32'(valid_out), 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_keep_out", 32'(keep_out), 0);
    chk("rst_last_out", 32'(last_out), 0);
    chk("rst_valid_hdr", 32'(valid_hdr), 0);
    chk("rst_data_hdr", data_hdr, 0);
    chk("rst_keep_hdr", 32'(keep_hdr), 0);
    chk("rst_ready_in", 32'(ready_in), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready_extract", 32'(ready_extract), 1);
    @(posedge clk); #1;

    // k=2, three full beats
    clear_obs(); load_k2_pkt(); send_pkt(4'b0011); drain();
    chk("k2_hdr_cnt", obs_hdr.size(), 1);
    chk("k2_out_cnt", obs_out.size(), 3);
    if (obs_hdr.size() > 0) begin
      chk("k2_hdr_lit", obs_hdr[0].d, 32'h0000AABB);
      chk("k2_hdr_keep_lit", 32'(obs_hdr[0].k), 32'h3);
    end
    if (obs_out.size() > 2) begin
      chk("k2_out0_lit", obs_out[0].d, 32'hCCDD1122);
      chk("k2_out1_lit", obs_out[1].d, 32'h33445566);
      chk("k2_out2_lit", obs_out[2].d, 32'h77880000);
      chk("k2_out2_keep_lit", 32'(obs_out[2].k), 32'hC);
      chk("k2_out2_last_lit", 32'(obs_out[2].l), 1);
    end

    // k=1, partial last beat exercises the tail path
    clear_obs();
    pk_d = '{32'hA1A2A3A4, 32'hB1B2B3B4}; pk_k = '{4'hF, 4'hC};
    send_pkt(4'b0001); drain();
    chk("k1_out_cnt", obs_out.size(), 2);
    if (obs_hdr.size() > 0) chk("k1_hdr_lit", obs_hdr[0].d, 32'h000000A1);
    if (obs_out.size() > 1) begin
      chk("k1_out0_lit", obs_out[0].d, 32'hA2A3A4B1);
      chk("k1_out0_last_lit", 32'(obs_out[0].l), 0);
      chk("k1_out1_lit", obs_out[1].d, 32'hB2000000);
      chk("k1_out1_keep_lit", 32'(obs_out[1].k), 32'h8);
    end

    // k=4: first beat is the header, payload unshifted
    clear_obs();
    pk_d = '{32'h10203040, 32'h50607080, 32'h90A0B0C0}; pk_k = '{4'hF, 4'hF, 4'hF};
    send_pkt(4'b1111); drain();
    if (obs_hdr.size() > 0) chk("k4_hdr_lit", obs_hdr[0].d, 32'h10203040);
    if (obs_out.size() > 1) chk("k4_out1_lit", obs_out[1].d, 32'h90A0B0C0);

    // k=0: plain pass-through, no header
    clear_obs();
    send_pkt(4'b0000); drain();
    chk("k0_hdr_cnt", obs_hdr.size(), 0);
    chk("k0_out_cnt", obs_out.size(), 3);
    if (obs_out.size() > 0) chk("k0_out0_lit", obs_out[0].d, 32'h10203040);

    // Header-only single beat
    clear_obs();
    pk_d = '{32'hDEADBEEF}; pk_k = '{4'hC};
    send_pkt(4'b0011); drain();
    chk("hdronly_out_cnt", obs_out.size(), 0);
    if (obs_hdr.size() > 0) chk("hdronly_hdr_lit", obs_hdr[0].d, 32'h0000DEAD);
    @(negedge clk);
    chk("hdronly_idle", 32'(ready_extract), 1);
    @(posedge clk); #1;

    // Random payload backpressure, header sink stalled for 20 cycles over two packets
    clear_obs();
    rand_rdy = 1'b1; hdr_hold = 1'b1;
    fork
      begin
        pk_d = '{32'h01020304, 32'h05060708, 32'h090A0B0C}; pk_k = '{4'hF, 4'hF, 4'hE};
        send_pkt(4'b0111);
        pk_d = '{32'h21222324, 32'h25262728, 32'h292A2B2C, 32'h2D2E2F30}; pk_k = '{4'hF, 4'hF, 4'hF, 4'h8};
        send_pkt(4'b0111);
      end
      begin
        repeat (20) @(posedge clk);
        hdr_hold = 1'b0;
      end
    join
    drain();
    rand_rdy = 1'b0;
    chk("bp_hdr_cnt", obs_hdr.size(), 2);
    chk("bp_out_cnt", obs_out.size(), 5);
    if (obs_hdr.size() > 1) begin
      chk("bp_hdr0_lit", obs_hdr[0].d, 32'h00010203);
      chk("bp_hdr1_lit", obs_hdr[1].d, 32'h00212223);
    end

    // Reset while in BODY: partial packet dropped, next packet clean
    clear_obs();
    exp_hdr.push_back('{d: 32'h00000001, k: 4'b0001, l: 1'b0});
    do_desc(4'b0001);
    do_beat(32'h01020304, 4'hF, 1'b0, 1'b1);
    do_beat(32'h05060708, 4'hF, 1'b0, 1'b0);
    idle_in();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid_out", 32'(valid_out), 0);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_keep_out", 32'(keep_out), 0);
    chk("midrst_last_out", 32'(last_out), 0);
    chk("midrst_valid_hdr", 32'(valid_hdr), 0);
    chk("midrst_data_hdr", data_hdr, 0);
    exp_out.delete();
    exp_hdr.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_obs(); load_k2_pkt(); send_pkt(4'b0011); drain();
    chk("postrst_out_cnt", obs_out.size(), 3);
    if (obs_hdr.size() > 0) chk("postrst_hdr_lit", obs_hdr[0].d, 32'h0000AABB);
    if (obs_out.size() > 0) chk("postrst_out0_lit", obs_out[0].d, 32'hCCDD1122);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
